mac_out_collector: RTL and testbench

- Receiving end of the 4x4 systolic MAC array output interface.
- The array produces its per-row partial sums skewed in time: row r emits ODATA lane r when OVALID[r] is high, and the rows are staggered by up to 3+ cycles.
- This block buffers each row lane in its own FIFO and re-aligns the lanes into complete 4-lane result vectors.
- It presents those vectors downstream on a valid/ready handshake, with overflow detection and a synchronous flush.

---
 rtl/mac_out_collector.sv | 139 +++++++++++++
 tb/tb_mac_out_collector.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_out_collector.sv
// Re-aligns the skewed per-row psum lanes of the 4x4 MAC array into complete result vectors.
// Optional build macro MAC_OUT_SAT8_EN clamps each output lane to [-128,127].
module mac_out_collector #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AFULL_TH = 6
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        CLR,
    input  logic [63:0] ODATA,
    input  logic [3:0]  OVALID,
    output logic [63:0] RES_DATA,
    output logic        RES_VALID,
    input  logic        RES_READY,
    output logic        ALMOST_FULL,
    output logic [3:0]  OVF,
    output logic [15:0] RES_CNT
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] wr_ptr_q [4];
    logic [PW-1:0] wr_ptr_d [4];
    logic [PW-1:0] rd_ptr_q [4];
    logic [PW-1:0] rd_ptr_d [4];
    logic [CW-1:0] count_q  [4];
    logic [CW-1:0] count_d  [4];
    logic [15:0]   mem_q    [4][DEPTH];
    logic [15:0]   mem_d    [4][DEPTH];
    logic [3:0]    ovf_q, ovf_d;
    logic [15:0]   res_cnt_q, res_cnt_d;
    logic [63:0]   hold_q, hold_d;

    logic          res_valid;
    logic          pop;
    logic          almost_full;
    logic [63:0]   head_data;

    function automatic logic [15:0] lane_out(input logic [15:0] v);
`ifdef MAC_OUT_SAT8_EN
        if ($signed(v) > $signed(16'sd127)) begin
            return 16'h007F;
        end else if ($signed(v) < $signed(-16'sd128)) begin
            return 16'hFF80;
        end else begin
            return v;
        end
`else
        return v;
`endif
    endfunction

    always_comb begin
        res_valid   = 1'b1;
        almost_full = 1'b0;
        head_data   = '0;
        for (int r = 0; r < 4; r++) begin
            res_valid   = res_valid & (count_q[r] != '0);
            almost_full = almost_full | (count_q[r] >= CW'(AFULL_TH));
            head_data[63-16*r -: 16] = lane_out(mem_q[r][rd_ptr_q[r]]);
        end
    end

    // Flush takes priority, so no transfer is taken in a CLR cycle.
    assign pop = res_valid & RES_READY & ~CLR;

    always_comb begin
        logic full;
        logic push;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        res_cnt_d = res_cnt_q + {15'd0, pop};
        hold_d    = res_valid ? head_data : hold_q;
        for (int r = 0; r < 4; r++) begin
            full = (count_q[r] == CW'(DEPTH));
            push = OVALID[r] & ~CLR & (~full | pop);
            if (push) begin
                mem_d[r][wr_ptr_q[r]] = ODATA[63-16*r -: 16];
                wr_ptr_d[r] = wr_ptr_q[r] + PW'(1);
            end
            if (pop) begin
                rd_ptr_d[r] = rd_ptr_q[r] + PW'(1);
            end
            if (push && !pop) begin
                count_d[r] = count_q[r] + CW'(1);
            end else if (pop && !push) begin
                count_d[r] = count_q[r] - CW'(1);
            end
            if (OVALID[r] && full && !pop) begin
                ovf_d[r] = 1'b1;
            end
            if (CLR) begin
                wr_ptr_d[r] = '0;
                rd_ptr_d[r] = '0;
                count_d[r]  = '0;
            end
        end
        if (CLR) begin
            ovf_d     = '0;
            res_cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int r = 0; r < 4; r++) begin
                wr_ptr_q[r] <= '0;
                rd_ptr_q[r] <= '0;
                count_q[r]  <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[r][i] <= '0;
                end
            end
            ovf_q     <= '0;
            res_cnt_q <= '0;
            hold_q    <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            mem_q     <= mem_d;
            ovf_q     <= ovf_d;
            res_cnt_q <= res_cnt_d;
            hold_q    <= hold_d;
        end
    end

    // When no vector is complete, the last presented vector is held.
    assign RES_DATA    = res_valid ? head_data : hold_q;
    assign RES_VALID   = res_valid;
    assign ALMOST_FULL = almost_full;
    assign OVF         = ovf_q;
    assign RES_CNT     = res_cnt_q;

endmodule

// File: tb/tb_mac_out_collector.sv
// Self-checking bench for mac_out_collector: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_mac_out_collector;

    localparam int DEPTH    = 8;
    localparam int AFULL_TH = 6;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        CLR;
    logic [63:0] ODATA;
    logic [3:0]  OVALID;
    logic [63:0] RES_DATA;
    logic        RES_VALID;
    logic        RES_READY;
    logic        ALMOST_FULL;
    logic [3:0]  OVF;
    logic [15:0] RES_CNT;

    int total = 0;
    int bad   = 0;

    mac_out_collector #(
        .DEPTH    (DEPTH),
        .AFULL_TH (AFULL_TH)
    ) dut (
        .CLK         (CLK),
        .RSTN        (RSTN),
        .CLR         (CLR),
        .ODATA       (ODATA),
        .OVALID      (OVALID),
        .RES_DATA    (RES_DATA),
        .RES_VALID   (RES_VALID),
        .RES_READY   (RES_READY),
        .ALMOST_FULL (ALMOST_FULL),
        .OVF         (OVF),
        .RES_CNT     (RES_CNT)
    );

    always #5 CLK = ~CLK;

    // Reference model: one queue per row plus sticky flags.
    logic [15:0] mq [4][$];
    logic [3:0]  m_ovf;
    logic [15:0] m_cnt;
    logic [63:0] m_last;

    function automatic logic [15:0] sat8(input logic [15:0] v);
`ifdef MAC_OUT_SAT8_EN
        int s;
        s = int'($signed(v));
        if (s > 127) return 16'h007F;
        if (s < -128) return 16'hFF80;
        return v;
`else
        return v;
`endif
    endfunction

    function automatic logic m_valid();
        for (int r = 0; r < 4; r++) if (mq[r].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [63:0] m_front();
        logic [63:0] d = '0;
        for (int r = 0; r < 4; r++) d[63-16*r -: 16] = sat8(mq[r][0]);
        return d;
    endfunction

    function automatic logic m_af();
        for (int r = 0; r < 4; r++) if (mq[r].size() >= AFULL_TH) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 4; r++) mq[r].delete();
        m_ovf  = '0;
        m_cnt  = '0;
        m_last = '0;
    endtask

    task automatic model_edge(input logic clr, input logic [3:0] ov, input logic [63:0] od,
                              input logic rdy);
        logic v;
        v = m_valid();
        if (v) m_last = m_front();
        if (clr) begin
            for (int r = 0; r < 4; r++) mq[r].delete();
            m_ovf = '0;
            m_cnt = '0;
        end else begin
            if (v && rdy) begin
                for (int r = 0; r < 4; r++) void'(mq[r].pop_front());
                m_cnt = m_cnt + 16'd1;
            end
            for (int r = 0; r < 4; r++) begin
                if (ov[r]) begin
                    if (mq[r].size() < DEPTH) mq[r].push_back(od[63-16*r -: 16]);
                    else m_ovf[r] = 1'b1;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model(input string tag);
        logic v;
        v = m_valid();
        chk({tag, ".valid"}, 64'(RES_VALID), 64'(v));
        chk({tag, ".data"}, RES_DATA, v ? m_front() : m_last);
        chk({tag, ".af"}, 64'(ALMOST_FULL), 64'(m_af()));
        chk({tag, ".ovf"}, 64'(OVF), 64'(m_ovf));
        chk({tag, ".cnt"}, 64'(RES_CNT), 64'(m_cnt));
    endtask

    task automatic step(input string tag, input logic clr, input logic [3:0] ov,
                        input logic [63:0] od, input logic rdy);
        CLR       = clr;
        OVALID    = ov;
        ODATA     = od;
        RES_READY = rdy;
        @(posedge CLK);
        model_edge(clr, ov, od, rdy);
        #1;
        cmp_model(tag);
    endtask

    typedef struct {
        logic        clr;
        logic [3:0]  ov;
        logic [63:0] od;
        logic        rdy;
        logic        exp_v;
        logic [63:0] exp_d;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t        tbl [7];
    logic [63:0] sat_exp;
    logic [63:0] exp0;
    logic [63:0] od;
    logic [3:0]  ov;

    initial begin
`ifdef MAC_OUT_SAT8_EN
        sat_exp = 64'h007F_FF80_007F_FF80;
`else
        sat_exp = 64'h0200_FE00_007F_FF80;
`endif
        tbl[0] = '{1'b0, 4'b0001, 64'h0001_0000_0000_0000, 1'b1, 1'b0, 64'h0, 16'd0};
        tbl[1] = '{1'b0, 4'b0010, 64'h0000_0002_0000_0000, 1'b1, 1'b0, 64'h0, 16'd0};
        tbl[2] = '{1'b0, 4'b0100, 64'h0000_0000_0003_0000, 1'b1, 1'b0, 64'h0, 16'd0};
        tbl[3] = '{1'b0, 4'b1000, 64'h0000_0000_0000_0004, 1'b1, 1'b1,
                   64'h0001_0002_0003_0004, 16'd0};
        tbl[4] = '{1'b0, 4'b0000, 64'h0, 1'b1, 1'b0, 64'h0001_0002_0003_0004, 16'd1};
        tbl[5] = '{1'b0, 4'b1111, 64'h0200_FE00_007F_FF80, 1'b0, 1'b1, sat_exp, 16'd1};
        tbl[6] = '{1'b0, 4'b0000, 64'h0, 1'b1, 1'b0, sat_exp, 16'd2};

        RSTN = 1'b0; CLR = 1'b0; OVALID = '0; ODATA = '0; RES_READY = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst.valid", 64'(RES_VALID), 64'd0);
        chk("rst.data", RES_DATA, 64'd0);
        chk("rst.af", 64'(ALMOST_FULL), 64'd0);
        chk("rst.ovf", 64'(OVF), 64'd0);
        chk("rst.cnt", 64'(RES_CNT), 64'd0);
        @(negedge CLK);
        RSTN = 1'b1;

        // Skewed arrival and saturation vectors.
        for (int i = 0; i < 7; i++) begin
            step("tbl", tbl[i].clr, tbl[i].ov, tbl[i].od, tbl[i].rdy);
            chk($sformatf("tbl%0d.valid", i), 64'(RES_VALID), 64'(tbl[i].exp_v));
            chk($sformatf("tbl%0d.data", i), RES_DATA, tbl[i].exp_d);
            chk($sformatf("tbl%0d.cnt", i), 64'(RES_CNT), 64'(tbl[i].exp_cnt));
        end

        // Backpressure: three skewed vectors, ready held low.
        step("bp.clr", 1'b1, 4'b0, 64'h0, 1'b0);
        for (int c = 0; c < 6; c++) begin
            ov = '0;
            od = '0;
            for (int r = 0; r < 4; r++) begin
                if (c - r >= 0 && c - r < 3) begin
                    ov[r] = 1'b1;
                    od[63-16*r -: 16] = 16'(16'h1000 + 16'h0100 * (c - r) + r);
                end
            end
            step("bp.fill", 1'b0, ov, od, 1'b0);
        end
        exp0 = {sat8(16'h1000), sat8(16'h1001), sat8(16'h1002), sat8(16'h1003)};
        for (int i = 0; i < 2; i++) begin
            step("bp.hold", 1'b0, 4'b0, 64'h0, 1'b0);
            chk("bp.hold.valid", 64'(RES_VALID), 64'd1);
            chk("bp.hold.data", RES_DATA, exp0);
        end
        for (int i = 0; i < 3; i++) step("bp.drain", 1'b0, 4'b0, 64'h0, 1'b1);
        chk("bp.end.valid", 64'(RES_VALID), 64'd0);
        chk("bp.end.cnt", 64'(RES_CNT), 64'd3);

        // Overflow on row 0, then fill the other rows.
        step("ovf.clr", 1'b1, 4'b0, 64'h0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            step("ovf.push", 1'b0, 4'b0001, {16'(16'h0200 + k), 48'h0}, 1'b0);
            if (k == 5) chk("ovf.af5", 64'(ALMOST_FULL), 64'd0);
            if (k == 6) chk("ovf.af6", 64'(ALMOST_FULL), 64'd1);
            if (k == 8) chk("ovf.ovf8", 64'(OVF), 64'd0);
            if (k == 9) chk("ovf.ovf9", 64'(OVF), 64'b0001);
        end
        for (int i = 0; i < DEPTH; i++) begin
            step("ovf.fill", 1'b0, 4'b1110,
                 {16'h0, 16'(16'h0300 + i), 16'(16'h0400 + i), 16'(16'h0500 + i)}, 1'b0);
        end

        // All rows full: push and pop on the same edge.
        step("fpp", 1'b0, 4'b1111, 64'h0600_0601_0602_0603, 1'b1);
        chk("fpp.ovf", 64'(OVF), 64'b0001);
        chk("fpp.cnt", 64'(RES_CNT), 64'd1);
        chk("fpp.af", 64'(ALMOST_FULL), 64'd1);
        chk("fpp.data", RES_DATA, {sat8(16'h0202), sat8(16'h0301), sat8(16'h0401),
                                   sat8(16'h0501)});

        // Drain to three buffered vectors, then flush with data on OVALID.
        for (int i = 0; i < 5; i++) step("fl.drain", 1'b0, 4'b0, 64'h0, 1'b1);
        step("fl.clr", 1'b1, 4'b1111, 64'h0700_0701_0702_0703, 1'b0);
        chk("fl.valid", 64'(RES_VALID), 64'd0);
        chk("fl.ovf", 64'(OVF), 64'd0);
        chk("fl.cnt", 64'(RES_CNT), 64'd0);
        chk("fl.af", 64'(ALMOST_FULL), 64'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step("rnd", ($urandom_range(0, 99) == 0), 4'($urandom_range(0, 15)),
                 {$urandom, $urandom}, ($urandom_range(0, 3) != 0));
        end

        // Asynchronous reset mid-stream.
        step("rst.pre", 1'b0, 4'b1111, 64'h0800_0801_0802_0803, 1'b0);
        step("rst.pre", 1'b0, 4'b0001, 64'h0900_0000_0000_0000, 1'b0);
        CLR = 1'b0; OVALID = '0; RES_READY = 1'b0;
        #1;
        RSTN = 1'b0;
        #1;
        chk("arst.valid", 64'(RES_VALID), 64'd0);
        chk("arst.data", RES_DATA, 64'd0);
        chk("arst.af", 64'(ALMOST_FULL), 64'd0);
        chk("arst.ovf", 64'(OVF), 64'd0);
        chk("arst.cnt", 64'(RES_CNT), 64'd0);
        model_reset();
        @(posedge CLK);
        @(negedge CLK);
        RSTN = 1'b1;
        step("post", 1'b0, 4'b1111, 64'h0A00_0A01_0A02_0A03, 1'b1);
        step("post", 1'b0, 4'b0000, 64'h0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
